// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush sequencer for the 5-stage pipeline.
// Combines hazard-unit freeze/flush, I/D cache wait and halt draining into
// per-stage latch enables and NOP-insert flushes. It also keeps saturating
// stall/flush counters and a sticky D-side timeout flag.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             hz_freeze,
  input  logic             hz_flush,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [WAIT_W-1:0]  wait_q;
  logic               halted_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   flush_q;

  // Raw (pre-reset-override) control decode and event strobes.
  logic pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic exmem_en_s, exmem_flush_s, memwb_en_s, memwb_flush_s;
  logic dwait_s;
  logic flush_acc_s;
  logic stall_inc_s;

  // Next-state and same-cycle latch control decode; first matching RUN condition wins.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    pc_en_s       = 1'b0;
    ifid_en_s     = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_en_s    = 1'b0;
    exmem_flush_s = 1'b0;
    memwb_en_s    = 1'b0;
    memwb_flush_s = 1'b0;
    dwait_s       = 1'b0;
    flush_acc_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        pc_en_s    = 1'b1;
        ifid_en_s  = 1'b1;
        idex_en_s  = 1'b1;
        exmem_en_s = 1'b1;
        memwb_en_s = 1'b1;
        if (dmem_req && !dhit) begin
          // EX/MEM is frozen, so hazard requests are dropped and re-presented later.
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_en_s     = 1'b0;
          exmem_en_s    = 1'b0;
          memwb_flush_s = 1'b1;
          dwait_s       = 1'b1;
        end else if (halt_mem) begin
          pc_en_s       = 1'b0;
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          state_d       = ST_DRAIN;
          drain_d       = '0;
        end else if (hz_flush) begin
          // Redirect target loads into PC even when the icache is missing.
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          flush_acc_s  = 1'b1;
        end else if (hz_freeze) begin
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          idex_flush_s = 1'b1;
        end else if (!ihit) begin
          pc_en_s      = 1'b0;
          ifid_flush_s = 1'b1;
        end else begin
          pc_en_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        exmem_flush_s = 1'b1;
        memwb_en_s    = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
    stall_inc_s = (state_q == ST_RUN) && !pc_en_s;
  end

  // Reset forces every enable and flush low in the same cycle.
  always_comb begin
    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b0;
    end else begin
      pc_en       = pc_en_s;
      ifid_en     = ifid_en_s;
      ifid_flush  = ifid_flush_s;
      idex_en     = idex_en_s;
      idex_flush  = idex_flush_s;
      exmem_en    = exmem_en_s;
      exmem_flush = exmem_flush_s;
      memwb_en    = memwb_en_s;
      memwb_flush = memwb_flush_s;
    end
  end

  // FSM state, drain counter and halted flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // D-miss wait counter and sticky timeout; the count restarts whenever the wait breaks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (dwait_s) begin
      if (wait_q != WAIT_LAST) begin
        wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= wait_q;
      end
      if (wait_q == WAIT_LAST) begin
        timeout_q <= 1'b1;
      end else begin
        timeout_q <= timeout_q;
      end
    end else begin
      wait_q    <= '0;
      timeout_q <= timeout_q;
    end
  end

  // Saturating performance counters; frozen outside RUN because the strobes are RUN-only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc_s && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_W'(1);
      end else begin
        stall_q <= stall_q;
      end
      if (flush_acc_s && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_W'(1);
      end else begin
        flush_q <= flush_q;
      end
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer (TIMEOUT=8, CNT_W=4 so that timeout
// and counter saturation are reachable in a short run).
module tb_pipeline_sequencer;

  localparam int CW = 4;

  // Control vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  // exmem_en, exmem_flush, memwb_en, memwb_flush
  localparam logic [8:0] C_OFF    = 9'b000000000;
  localparam logic [8:0] C_NORM   = 9'b110101010;
  localparam logic [8:0] C_FREEZE = 9'b000111010;
  localparam logic [8:0] C_DMISS  = 9'b000000011;
  localparam logic [8:0] C_BRANCH = 9'b111111010;
  localparam logic [8:0] C_IMISS  = 9'b011101010;
  localparam logic [8:0] C_HALT   = 9'b011111110;
  localparam logic [8:0] C_DRAIN  = 9'b000000110;

  logic CLK = 1'b0;
  logic RST, ihit, dmem_req, dhit, hz_freeze, hz_flush, halt_mem;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush;
  logic halted, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, memwb_flush};

  always #5 CLK = ~CLK;

  pipeline_sequencer #(.DRAIN_CYCLES(2), .TIMEOUT(8), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .hz_freeze(hz_freeze), .hz_flush(hz_flush), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic drive(input logic ih, input logic dr, input logic dh,
                       input logic fz, input logic fl, input logic hm);
    ihit = ih; dmem_req = dr; dhit = dh; hz_freeze = fz; hz_flush = fl; halt_mem = hm;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_OFF) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_OFF); end
    step(); step();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (flush_cnt !== 4'd0) begin n_err++; $display("FAIL reset_flush got %0d want 0", flush_cnt); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
    RST = 1'b0;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL release_ctl got %b want %b", ctl, C_NORM); end
    step();
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL idle_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_FREEZE) begin n_err++; $display("FAIL freeze_ctl got %b want %b", ctl, C_FREEZE); end
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL freeze_stall got %0d want 1", stall_cnt); end
  endtask

  task automatic test_dmiss();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (ctl !== C_DMISS) begin n_err++; $display("FAIL dmiss_ctl[%0d] got %b want %b", i, ctl, C_DMISS); end
      step();
    end
    n_cmp++; if (flush_cnt !== 4'd0) begin n_err++; $display("FAIL dmiss_flush got %0d want 0", flush_cnt); end
    n_cmp++; if (stall_cnt !== 4'd6) begin n_err++; $display("FAIL dmiss_stall got %0d want 6", stall_cnt); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL dmiss_timeout got %b want 0", mem_timeout); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_BRANCH) begin n_err++; $display("FAIL dhit_flush_ctl got %b want %b", ctl, C_BRANCH); end
    step();
    n_cmp++; if (flush_cnt !== 4'd1) begin n_err++; $display("FAIL dhit_flush_cnt got %0d want 1", flush_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch_imiss();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_BRANCH) begin n_err++; $display("FAIL br_imiss_ctl got %b want %b", ctl, C_BRANCH); end
    step();
    n_cmp++; if (flush_cnt !== 4'd2) begin n_err++; $display("FAIL br_imiss_flush got %0d want 2", flush_cnt); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_IMISS) begin n_err++; $display("FAIL imiss_ctl got %b want %b", ctl, C_IMISS); end
    step();
    n_cmp++; if (stall_cnt !== 4'd7) begin n_err++; $display("FAIL imiss_stall got %0d want 7", stall_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early got %b want 0", mem_timeout); end
    step();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set got %b want 1", mem_timeout); end
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL timeout_stall got %0d want 15", stall_cnt); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got %b want 1", mem_timeout); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL stall_saturate got %0d want 15", stall_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (ctl !== C_DMISS) begin n_err++; $display("FAIL prio_dmiss got %b want %b", ctl, C_DMISS); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_BRANCH) begin n_err++; $display("FAIL prio_flush got %b want %b", ctl, C_BRANCH); end
    step();
    n_cmp++; if (flush_cnt !== 4'd3) begin n_err++; $display("FAIL prio_flush_cnt got %0d want 3", flush_cnt); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_FREEZE) begin n_err++; $display("FAIL prio_freeze got %b want %b", ctl, C_FREEZE); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    n_cmp++; if (ctl !== C_HALT) begin n_err++; $display("FAIL halt_ctl got %b want %b", ctl, C_HALT); end
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (ctl !== C_DRAIN) begin n_err++; $display("FAIL drain_ctl[%0d] got %b want %b", i, ctl, C_DRAIN); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL drain_halted[%0d] got %b want 0", i, halted); end
      step();
    end
    for (int i = 0; i < 20; i++) begin
      {ihit, dmem_req, dhit, hz_freeze, hz_flush, halt_mem} = 6'($urandom);
      #1;
      n_cmp++; if ({halted, ctl} !== {1'b1, C_OFF}) begin n_err++; $display("FAIL halted_hold[%0d] got halted=%b ctl=%b want 1 %b", i, halted, ctl, C_OFF); end
      step();
    end
    n_cmp++; if (flush_cnt !== 4'd3) begin n_err++; $display("FAIL halt_flush_frozen got %0d want 3", flush_cnt); end
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL halt_stall_frozen got %0d want 15", stall_cnt); end
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    RST = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL unhalt got %b want 0", halted); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL unhalt_timeout got %b want 0", mem_timeout); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL unhalt_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL unhalt_ctl got %b want %b", ctl, C_NORM); end
    step();
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (ctl !== C_DRAIN) begin n_err++; $display("FAIL middrain_ctl got %b want %b", ctl, C_DRAIN); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL middrain_run got %b want %b", ctl, C_NORM); end
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL middrain_halted got %b want 0", halted); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL middrain_stall got %0d want 0", stall_cnt); end
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    test_reset();
    test_load_use();
    test_dmiss();
    test_branch_imiss();
    test_timeout();
    test_priority();
    test_halt();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
